// File: rtl/lb_uart_tx_fifo.sv
// lb_uart_tx_fifo: buffered UART transmitter.
// Words pushed through a cs/we strobe go into a FIFO and are serialised
// on tx as start bit, 8 or 9 data bits LSB first, optional parity bit,
// and 1 or 2 stop bits. Frame format and bit period are captured when a
// word is popped, so later config changes affect only later frames.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   cs, we, data      push request (cs & we) and 9-bit word
//   bit8, parity_en, odd_n_even, stop2, baud_val   frame configuration
//   clr_ovf           clears the sticky overflow flag
//   txrdy             FIFO not full
//   tx, tx_busy       serial line (idle 1) and frame-in-progress flag
//   fifo_count        words held in the FIFO
//   ovf               sticky: a push was dropped because the FIFO was full
//   break_req         only with LB_UART_TX_BREAK_EN: hold a line break
//
// Optional feature macro: LB_UART_TX_BREAK_EN
module lb_uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BAUD_W     = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cs,
    input  logic                          we,
    input  logic [8:0]                    data,
    input  logic                          bit8,
    input  logic                          parity_en,
    input  logic                          odd_n_even,
    input  logic                          stop2,
    input  logic [BAUD_W-1:0]             baud_val,
    input  logic                          clr_ovf,
`ifdef LB_UART_TX_BREAK_EN
    input  logic                          break_req,
`endif
    output logic                          txrdy,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovf
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef LB_UART_TX_BREAK_EN
        ,
        S_BREAK,
        S_MARK
`endif
    } state_t;

    state_t            state;
    logic [8:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [8:0]        shreg;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] l_baud;
    logic [3:0]        bit_cnt;
    logic              l_bit8;
    logic              l_par_en;
    logic              l_stop2;
    logic              par_bit;

    logic              push_c;
    logic              pop_c;
    logic              bit_end_c;
    logic              last_stop_c;
    logic              fifo_empty_c;
    logic [8:0]        frame_word_c;
    logic [3:0]        last_idx_c;

    // Full flag comes straight from the registered count, so a same-cycle pop never frees a slot
    assign txrdy        = (fifo_count != CW'(FIFO_DEPTH));
    assign push_c       = cs & we & txrdy;
    assign fifo_empty_c = (fifo_count == '0);
    assign bit_end_c    = (baud_cnt == l_baud);
    assign last_stop_c  = bit_end_c && (!l_stop2 || bit_cnt[0]);
    assign last_idx_c   = l_bit8 ? 4'd8 : 4'd7;
    // data[8] only takes part in 9-bit frames
    assign frame_word_c = {mem[rd_ptr][8] & bit8, mem[rd_ptr][7:0]};

    // Pop at every frame boundary where a word is waiting
    always_comb begin
        pop_c = 1'b0;
        case (state)
            S_IDLE:  pop_c = !fifo_empty_c;
            S_STOP:  pop_c = last_stop_c && !fifo_empty_c;
`ifdef LB_UART_TX_BREAK_EN
            S_MARK:  pop_c = bit_end_c && !fifo_empty_c;
`endif
            default: pop_c = 1'b0;
        endcase
`ifdef LB_UART_TX_BREAK_EN
        // A pending break wins over the next frame
        if (break_req && (state == S_IDLE || state == S_STOP)) begin
            pop_c = 1'b0;
        end
`endif
    end

    // FIFO storage (no reset needed, validity is tracked by the count)
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= data;
        end
    end

    // FIFO pointers, count and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_c && !pop_c) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!push_c && pop_c) begin
                fifo_count <= fifo_count - CW'(1);
            end
            // A new drop beats a simultaneous clear
            if (cs && we && !txrdy) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Transmit FSM; the pop override at the end starts a frame from any boundary state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            shreg    <= '0;
            baud_cnt <= '0;
            l_baud   <= '0;
            bit_cnt  <= '0;
            l_bit8   <= 1'b0;
            l_par_en <= 1'b0;
            l_stop2  <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            if (state != S_IDLE) begin
                baud_cnt <= bit_end_c ? '0 : baud_cnt + BAUD_W'(1);
            end
            case (state)
                S_IDLE: begin
                    tx       <= 1'b1;
                    tx_busy  <= 1'b0;
                    baud_cnt <= '0;
`ifdef LB_UART_TX_BREAK_EN
                    if (break_req) begin
                        state   <= S_BREAK;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
`endif
                end
                S_START: begin
                    if (bit_end_c) begin
                        state   <= S_DATA;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[8:1]};
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        if (bit_cnt == last_idx_c) begin
                            bit_cnt <= '0;
                            if (l_par_en) begin
                                state <= S_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[8:1]};
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end_c) begin
                        state   <= S_STOP;
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                S_STOP: begin
                    if (bit_end_c) begin
                        if (!last_stop_c) begin
                            bit_cnt <= 4'd1;
                        end else begin
                            state   <= S_IDLE;
                            tx      <= 1'b1;
                            tx_busy <= 1'b0;
`ifdef LB_UART_TX_BREAK_EN
                            if (break_req) begin
                                state   <= S_BREAK;
                                tx      <= 1'b0;
                                tx_busy <= 1'b1;
                            end
`endif
                        end
                    end
                end
`ifdef LB_UART_TX_BREAK_EN
                S_BREAK: begin
                    baud_cnt <= '0;
                    if (!break_req) begin
                        state  <= S_MARK;
                        tx     <= 1'b1;
                        l_baud <= baud_val;
                    end
                end
                S_MARK: begin
                    if (bit_end_c) begin
                        state   <= S_IDLE;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (pop_c) begin
                state    <= S_START;
                tx       <= 1'b0;
                tx_busy  <= 1'b1;
                baud_cnt <= '0;
                shreg    <= frame_word_c;
                l_bit8   <= bit8;
                l_par_en <= parity_en;
                l_stop2  <= stop2;
                l_baud   <= baud_val;
                par_bit  <= (^frame_word_c) ^ odd_n_even;
            end
        end
    end

endmodule

// File: tb/tb_lb_uart_tx_fifo.sv
// Testbench for lb_uart_tx_fifo (FIFO_DEPTH=4): table-driven single frames,
// hand sequences for overflow, reset mid-frame, config stability and
// (with LB_UART_TX_BREAK_EN) break, plus randomized bursts. Expected tx and
// tx_busy streams are built per cycle from frame rules and compared with a
// negedge recording of the DUT.
module tb_lb_uart_tx_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BW    = 20;

    logic          clk;
    logic          reset;
    logic          cs;
    logic          we;
    logic [8:0]    data;
    logic          bit8;
    logic          parity_en;
    logic          odd_n_even;
    logic          stop2;
    logic [BW-1:0] baud_val;
    logic          clr_ovf;
`ifdef LB_UART_TX_BREAK_EN
    logic          break_req;
`endif
    logic          txrdy;
    logic          tx;
    logic          tx_busy;
    logic [2:0]    fifo_count;
    logic          ovf;

    lb_uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .BAUD_W(BW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .we         (we),
        .data       (data),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .stop2      (stop2),
        .baud_val   (baud_val),
        .clr_ovf    (clr_ovf),
`ifdef LB_UART_TX_BREAK_EN
        .break_req  (break_req),
`endif
        .txrdy      (txrdy),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        bit         b8;
        bit         par;
        bit         odd;
        bit         s2;
        int         baud;
        int         exp_cycles;
        bit         exp_par;
    } vec_t;

    vec_t       vecs [6];
    int         tests;
    int         fails;
    bit         rec_en;
    bit         rec_tx[$];
    bit         rec_busy[$];
    bit         exp_tx[$];
    bit         exp_busy[$];
    logic [8:0] rw [4];
    logic [8:0] ow [6];

    always @(negedge clk) begin
        if (rec_en) begin
            rec_tx.push_back(tx);
            rec_busy.push_back(tx_busy);
        end
    end

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_level(bit v, bit busy, int n);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(v);
            exp_busy.push_back(busy);
        end
    endfunction

    // One frame, each bit repeated baud+1 cycles
    function automatic void add_frame(logic [8:0] w, bit b8, bit par, bit odd, bit s2, int baud);
        bit bits[$];
        int nb;
        int ones;
        nb   = b8 ? 9 : 8;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (par) bits.push_back(((ones % 2) == 1) ^ odd);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) add_level(bits[i], 1'b1, baud + 1);
    endfunction

    // Call after driving the first push, before its edge: two idle samples precede the frame
    task automatic start_rec();
        rec_tx.delete();
        rec_busy.delete();
        exp_tx.delete();
        exp_busy.delete();
        rec_en = 1'b1;
        add_level(1'b1, 1'b0, 2);
    endtask

    task automatic finish_stream(input string name);
        int bad_tx;
        int bad_busy;
        bad_tx   = 0;
        bad_busy = 0;
        for (int i = 0; i < exp_tx.size() + 5 && rec_tx.size() < exp_tx.size(); i++) step();
        for (int i = 0; i < exp_tx.size(); i++) begin
            if (i >= rec_tx.size()) begin
                bad_tx++;
                bad_busy++;
            end else begin
                if (rec_tx[i] != exp_tx[i]) bad_tx++;
                if (rec_busy[i] != exp_busy[i]) bad_busy++;
            end
        end
        rec_en = 1'b0;
        check({name, "_tx_bad_samples"}, bad_tx, 0);
        check({name, "_busy_bad_samples"}, bad_busy, 0);
    endtask

    task automatic set_cfg(input bit b8, input bit par, input bit odd, input bit s2, input int baud);
        bit8       = b8;
        parity_en  = par;
        odd_n_even = odd;
        stop2      = s2;
        baud_val   = BW'(baud);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int pidx;
        int nb;
        int n;
        int b;
        tests = 0;
        fails = 0;
        rec_en = 1'b0;
        reset = 1'b0;
        cs = 1'b0;
        we = 1'b0;
        data = '0;
        clr_ovf = 1'b0;
`ifdef LB_UART_TX_BREAK_EN
        break_req = 1'b0;
`endif
        set_cfg(0, 0, 0, 0, 3);

        vecs[0] = '{9'h0A5, 0, 1, 1, 0, 3, 44, 1};
        vecs[1] = '{9'h1A5, 1, 1, 1, 0, 3, 48, 0};
        vecs[2] = '{9'h000, 0, 0, 0, 0, 0, 10, 0};
        vecs[3] = '{9'h1FF, 1, 1, 0, 1, 1, 26, 1};
        vecs[4] = '{9'h155, 0, 1, 0, 1, 2, 36, 0};
        vecs[5] = '{9'h003, 1, 0, 0, 1, 0, 12, 0};

        // Reset state
        step();
        step();
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_txrdy", int'(txrdy), 1);
        reset = 1'b1;
        step();

        // Single frames from the table
        foreach (vecs[v]) begin
            set_cfg(vecs[v].b8, vecs[v].par, vecs[v].odd, vecs[v].s2, vecs[v].baud);
            data = vecs[v].data;
            cs = 1'b1;
            we = 1'b1;
            start_rec();
            add_frame(vecs[v].data, vecs[v].b8, vecs[v].par, vecs[v].odd, vecs[v].s2, vecs[v].baud);
            add_level(1'b1, 1'b0, 4);
            step();
            cs = 1'b0;
            we = 1'b0;
            check($sformatf("v%0d_count_after_push", v), int'(fifo_count), 1);
            check($sformatf("v%0d_tx_before_pop", v), int'(tx), 1);
            step();
            check($sformatf("v%0d_tx_start", v), int'(tx), 0);
            check($sformatf("v%0d_count_after_pop", v), int'(fifo_count), 0);
            finish_stream($sformatf("v%0d", v));
            busy_cnt = 0;
            foreach (rec_busy[i]) busy_cnt += int'(rec_busy[i]);
            check($sformatf("v%0d_frame_cycles", v), busy_cnt, vecs[v].exp_cycles);
            if (vecs[v].par) begin
                nb = vecs[v].b8 ? 9 : 8;
                pidx = 2 + (1 + nb) * (vecs[v].baud + 1);
                check($sformatf("v%0d_parity", v), (pidx < rec_tx.size()) ? int'(rec_tx[pidx]) : -1,
                      int'(vecs[v].exp_par));
            end
        end

        // Overflow with 6 consecutive pushes into a depth-4 FIFO
        set_cfg(0, 0, 0, 0, 100);
        for (int i = 0; i < 6; i++) ow[i] = 9'(17 * (i + 1));
        for (int i = 0; i < 6; i++) begin
            cs = 1'b1;
            we = 1'b1;
            data = ow[i];
            if (i == 0) start_rec();
            step();
            if (i == 3) begin
                check("ovf_txrdy_after_4", int'(txrdy), 1);
                check("ovf_count_after_4", int'(fifo_count), 3);
            end
            if (i == 4) begin
                check("ovf_txrdy_after_5", int'(txrdy), 0);
                check("ovf_count_after_5", int'(fifo_count), 4);
                check("ovf_flag_after_5", int'(ovf), 0);
            end
            if (i == 5) begin
                check("ovf_flag_after_6", int'(ovf), 1);
                check("ovf_count_after_6", int'(fifo_count), 4);
            end
        end
        for (int i = 0; i < 5; i++) add_frame(ow[i], 0, 0, 0, 0, 100);
        add_level(1'b1, 1'b0, 4);
        cs = 1'b0;
        we = 1'b0;
        step();
        check("ovf_sticky", int'(ovf), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", int'(ovf), 0);
        cs = 1'b1;
        we = 1'b1;
        clr_ovf = 1'b1;
        data = 9'h1EE;
        step();
        cs = 1'b0;
        we = 1'b0;
        clr_ovf = 1'b0;
        check("ovf_drop_beats_clear", int'(ovf), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared_again", int'(ovf), 0);
        finish_stream("ovf_stream");

        // Reset during the data bits
        set_cfg(0, 0, 0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            cs = 1'b1;
            we = 1'b1;
            data = 9'(8'hF0 >> i);
            step();
        end
        cs = 1'b0;
        we = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("mid_busy_before_reset", int'(tx_busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_tx", int'(tx), 1);
        check("mid_rst_count", int'(fifo_count), 0);
        check("mid_rst_txrdy", int'(txrdy), 1);
        check("mid_rst_busy", int'(tx_busy), 0);
        step();
        reset = 1'b1;
        start_rec();
        add_level(1'b1, 1'b0, 60);
        finish_stream("mid_rst_after");

        // Baud change mid-frame applies to the next frame only
        set_cfg(0, 0, 0, 0, 3);
        cs = 1'b1;
        we = 1'b1;
        data = 9'h03C;
        start_rec();
        step();
        data = 9'h0C3;
        step();
        cs = 1'b0;
        we = 1'b0;
        for (int i = 0; i < 10; i++) step();
        baud_val = BW'(7);
        add_frame(9'h03C, 0, 0, 0, 0, 3);
        add_frame(9'h0C3, 0, 0, 0, 0, 7);
        add_level(1'b1, 1'b0, 4);
        finish_stream("cfg_baud");

`ifdef LB_UART_TX_BREAK_EN
        // Break raised mid-frame, held, released
        set_cfg(0, 0, 0, 0, 3);
        cs = 1'b1;
        we = 1'b1;
        data = 9'h05A;
        start_rec();
        step();
        data = 9'h0E1;
        step();
        cs = 1'b0;
        we = 1'b0;
        for (int i = 2; i <= 10; i++) step();
        break_req = 1'b1;
        for (int i = 11; i <= 70; i++) begin
            step();
            if (i == 60) check("brk_no_pop", int'(fifo_count), 1);
        end
        break_req = 1'b0;
        add_frame(9'h05A, 0, 0, 0, 0, 3);
        add_level(1'b0, 1'b1, 30);
        add_level(1'b1, 1'b1, 4);
        add_frame(9'h0E1, 0, 0, 0, 0, 3);
        add_level(1'b1, 1'b0, 4);
        finish_stream("brk");
`endif

        // Randomized bursts against the frame model
        for (int it = 0; it < 15; it++) begin
            b = int'($urandom_range(0, 5));
            set_cfg(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), b);
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < 4; k++) rw[k] = 9'($urandom);
            for (int k = 0; k < n; k++) begin
                if (k > 0 && ($urandom % 2) == 1) begin
                    cs = 1'($urandom);
                    we = !cs;
                    data = 9'($urandom);
                    step();
                end
                cs = 1'b1;
                we = 1'b1;
                data = rw[k];
                if (k == 0) start_rec();
                step();
            end
            cs = 1'b0;
            we = 1'b0;
            for (int k = 0; k < n; k++) add_frame(rw[k], bit8, parity_en, odd_n_even, stop2, b);
            add_level(1'b1, 1'b0, 4);
            finish_stream($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_ovf", it), int'(ovf), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lb_uart_tx_fifo.md
LB_UART_TX_FIFO -- requirements
Module: lb_uart_tx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, TX word-buffer depth; power of two, 2..256.
REQ-002 SHALL have parameter BAUD_W, default 20, width of baud_val.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cs  input  1  chip select.
REQ-006 SHALL have port we  input  1  write strobe; a push is requested when cs=1 and we=1.
REQ-007 SHALL have port data  input  9  TX word; data[8] is used only when bit8=1.
REQ-008 SHALL have port bit8  input  1  1 = 9 data bits, 0 = 8 data bits.
REQ-009 SHALL have port parity_en  input  1  1 = append parity bit.
REQ-010 SHALL have port odd_n_even  input  1  1 = odd parity, 0 = even parity.
REQ-011 SHALL have port stop2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-012 SHALL have port baud_val  input  BAUD_W  bit period minus 1, in clk cycles.
REQ-013 SHALL have port clr_ovf  input  1  clears the ovf flag.
REQ-014 SHALL have port txrdy  output  1  FIFO not full.
REQ-015 SHALL have port tx  output  1  serial line; idle level is 1.
REQ-016 SHALL have port tx_busy  output  1  a frame is in progress.
REQ-017 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO.
REQ-018 SHALL have port ovf  output  1  sticky flag: a push was dropped.

Function
REQ-019 SHALL accept a push only when txrdy=1 in that cycle; the accepted word enters the FIFO at that edge.
- txrdy = (fifo_count != FIFO_DEPTH), derived combinationally from the registered count.
- A pop in the same cycle SHALL NOT make room for a push in that cycle.
REQ-020 SHALL set ovf on a push request made while txrdy=0, and drop that word.
- ovf stays set until a cycle with clr_ovf=1.
- If clr_ovf and a new drop occur in the same cycle, ovf SHALL be 1.
REQ-021 SHALL implement states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when the FIFO is non-empty; the word is popped on that edge.
- START -> DATA after one bit period.
- DATA -> PARITY after the last data bit if parity_en=1; otherwise DATA -> STOP.
- PARITY -> STOP after one bit period.
- STOP -> START if the FIFO is non-empty, else STOP -> IDLE.
REQ-022 SHALL latch bit8, parity_en, odd_n_even, stop2 and baud_val at the pop edge; changes during a frame SHALL affect only later frames.
REQ-023 SHALL hold every bit for exactly baud_val+1 clk cycles; baud_val=0 gives 1-cycle bits.
REQ-024 SHALL drive tx as: start bit 0, data bits LSB first (8 or 9), optional parity bit, then 1 or 2 stop bits of 1.
REQ-025 SHALL compute the parity bit over all transmitted data bits: XOR of the data bits for even parity, its inverse for odd parity.
REQ-026 SHALL pop the first word on the edge after the push edge, with tx going to 0 on that pop edge.
REQ-027 SHALL start back-to-back frames with no idle cycle between the last stop bit and the next start bit.
REQ-028 SHALL assert tx_busy in every state except IDLE.
REQ-029 SHALL register tx, with no combinational path from any input to tx.

Reset
REQ-030 SHALL, while reset=0, asynchronously force:
- tx=1, tx_busy=0, ovf=0
- fifo_count=0, txrdy=1
- state=IDLE, baud and bit counters cleared
REQ-031 SHALL, on reset asserted mid-frame, abort the frame, drive tx=1 immediately, and discard all buffered words.

Configuration
REQ-032 SHALL, when macro LB_UART_TX_BREAK_EN is defined, add port break_req (input, 1 bit).
- While break_req=1, at the next frame boundary (IDLE, or after the current stop bits complete) the block SHALL drive tx=0 and hold it.
- No pops occur while break is held; tx_busy=1 throughout.
- When break_req returns to 0, the block SHALL drive one bit period of tx=1, then resume from the FIFO.
REQ-033 SHALL, without LB_UART_TX_BREAK_EN, have no break_req port and no break logic.

Verification
REQ-034 SHALL cover frame 1: baud_val=3, bit8=0, parity_en=1, odd_n_even=1, stop2=0, push 0x0A5.
- tx low 2nd edge after push; bits 0,1,0,1,0,0,1,0,1, parity 1, stop 1.
- 44 cycles total, then tx_busy=0.
REQ-035 SHALL cover frame 2: same settings with bit8=1, push 0x1A5.
- 9 data bits ending 1, parity 0, 48 cycles total.
REQ-036 SHALL cover overflow: FIFO_DEPTH=4, baud_val=100, push 6 words on consecutive cycles.
- 5 words accepted; txrdy=0 after the 5th push; 6th word dropped; ovf=1.
- clr_ovf pulse -> ovf=0.
- All 5 words transmitted back-to-back in order.
REQ-037 SHALL cover reset mid-frame: assert reset during DATA.
- tx=1, fifo_count=0, txrdy=1 immediately; no frame resumes after release.
REQ-038 SHALL cover config stability: change baud_val 3 -> 7 mid-frame.
- Current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
REQ-039 SHALL cover break (LB_UART_TX_BREAK_EN defined): raise break_req mid-frame.
- Frame completes; tx=0 while break_req held; one 1-bit after release; queued word then sent.
